health_round_tracker: RTL and testbench

Gameplay-side scorekeeper sitting directly upstream of the game state controller. It holds both players' health and the round clock. It applies damage from hit events, with a blocking reduction and per-player invulnerability frames. It produces the `game_over_condition`, `winner_p1` and `winner_p2` signals that the state controller consumes, and it obeys that controller's `reset_gameplay`, `timer_enable` and `timer_reset` outputs.

---
 rtl/health_round_tracker.sv | 197 +++++++++++++++++++
 tb/tb_health_round_tracker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/health_round_tracker.sv
// -----------------------------------------------------------------------------
// health_round_tracker
//
// Gameplay scorekeeper for a two-player fighting game. It holds both players'
// health and the round clock, and applies damage from hit events with a
// blocking reduction and per-player invulnerability frames. It reports the
// round result to the downstream game state controller and obeys that
// controller's gameplay reset and timer controls.
//
// Ports:
//   clk_game            in   game clock (60 Hz), single clock domain
//   reset_n             in   synchronous active-low reset
//   reset_gameplay      in   level: force IDLE, reload health and round clock
//   timer_enable        in   level: allow the round clock to count
//   timer_reset         in   level: reload the round clock only
//   p1_hit_p2           in   P1 attack connects with P2 this cycle
//   p2_hit_p1           in   P2 attack connects with P1 this cycle
//   p1_blocking         in   P1 guard held
//   p2_blocking         in   P2 guard held
//   p1_health     [7:0] out  current P1 health
//   p2_health     [7:0] out  current P2 health
//   round_seconds [6:0] out  seconds remaining in the round
//   p1_invuln           out  P1 invulnerability counter nonzero
//   p2_invuln           out  P2 invulnerability counter nonzero
//   game_over_condition out  round ended (latched)
//   winner_p1           out  P1 won (latched, valid with game_over_condition)
//   winner_p2           out  P2 won (latched, valid with game_over_condition)
// -----------------------------------------------------------------------------
module health_round_tracker #(
    parameter logic [7:0] MAX_HEALTH    = 8'd100,
    parameter logic [7:0] HIT_DAMAGE    = 8'd10,
    parameter logic [7:0] BLOCK_DAMAGE  = 8'd2,
    parameter logic [5:0] IFRAMES       = 6'd30,
    parameter logic [6:0] ROUND_SECONDS = 7'd99,
    parameter logic [5:0] TICKS_PER_SEC = 6'd60
) (
    input  logic       clk_game,
    input  logic       reset_n,
    input  logic       reset_gameplay,
    input  logic       timer_enable,
    input  logic       timer_reset,
    input  logic       p1_hit_p2,
    input  logic       p2_hit_p1,
    input  logic       p1_blocking,
    input  logic       p2_blocking,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic [6:0] round_seconds,
    output logic       p1_invuln,
    output logic       p2_invuln,
    output logic       game_over_condition,
    output logic       winner_p1,
    output logic       winner_p2
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIGHT,
        ST_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] p1_health_d, p2_health_d;
    logic [6:0] seconds_d;
    logic [5:0] tick_q, tick_d;
    logic [5:0] p1_iframe_q, p1_iframe_d;
    logic [5:0] p2_iframe_q, p2_iframe_d;
    logic       game_over_d, winner_p1_d, winner_p2_d;
    logic       ko, time_up;

    // Health never wraps below zero.
    function automatic logic [7:0] sat_sub(input logic [7:0] value, input logic [7:0] amount);
        return (value > amount) ? (value - amount) : 8'd0;
    endfunction

    // Invulnerability flags come straight from the counter registers, so no
    // input reaches them combinationally.
    assign p1_invuln = (p1_iframe_q != 6'd0);
    assign p2_invuln = (p2_iframe_q != 6'd0);

    // -------------------------------------------------------------------------
    // Next-state and next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        p1_health_d = p1_health;
        p2_health_d = p2_health;
        seconds_d   = round_seconds;
        tick_d      = tick_q;
        game_over_d = game_over_condition;
        winner_p1_d = winner_p1;
        winner_p2_d = winner_p2;
        p1_iframe_d = (p1_iframe_q != 6'd0) ? (p1_iframe_q - 6'd1) : 6'd0;
        p2_iframe_d = (p2_iframe_q != 6'd0) ? (p2_iframe_q - 6'd1) : 6'd0;
        ko          = 1'b0;
        time_up     = 1'b0;

        case (state_q)
            // Entry edge into FIGHT applies no damage and does no counting.
            ST_IDLE: state_d = ST_FIGHT;

            ST_FIGHT: begin
                // P1 is the target of P2's attack and vice versa; a hit during
                // invulnerability is simply dropped.
                if (p2_hit_p1 && (p1_iframe_q == 6'd0)) begin
                    p1_health_d = sat_sub(p1_health, p1_blocking ? BLOCK_DAMAGE : HIT_DAMAGE);
                    p1_iframe_d = IFRAMES;
                end
                if (p1_hit_p2 && (p2_iframe_q == 6'd0)) begin
                    p2_health_d = sat_sub(p2_health, p2_blocking ? BLOCK_DAMAGE : HIT_DAMAGE);
                    p2_iframe_d = IFRAMES;
                end

                if (timer_reset) begin
                    seconds_d = ROUND_SECONDS;
                    tick_d    = 6'd0;
                end else if (timer_enable) begin
                    if (tick_q == (TICKS_PER_SEC - 6'd1)) begin
                        tick_d    = 6'd0;
                        seconds_d = (round_seconds != 7'd0) ? (round_seconds - 7'd1) : 7'd0;
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end

                ko      = (p1_health_d == 8'd0) || (p2_health_d == 8'd0);
                time_up = (seconds_d == 7'd0) && (round_seconds != 7'd0);

                if (ko || time_up) begin
                    state_d     = ST_OVER;
                    game_over_d = 1'b1;
                    // KO outranks time-up; a double KO or equal health is a draw.
                    if (ko) begin
                        winner_p1_d = (p2_health_d == 8'd0) && (p1_health_d != 8'd0);
                        winner_p2_d = (p1_health_d == 8'd0) && (p2_health_d != 8'd0);
                    end else begin
                        winner_p1_d = (p1_health_d > p2_health_d);
                        winner_p2_d = (p2_health_d > p1_health_d);
                    end
                end
            end

            // Everything frozen except the invulnerability countdown.
            ST_OVER: state_d = ST_OVER;

            default: state_d = ST_IDLE;
        endcase

        // Gameplay reset outranks every other input, including same-edge hits.
        if (reset_gameplay) begin
            state_d     = ST_IDLE;
            p1_health_d = MAX_HEALTH;
            p2_health_d = MAX_HEALTH;
            seconds_d   = ROUND_SECONDS;
            tick_d      = 6'd0;
            p1_iframe_d = 6'd0;
            p2_iframe_d = 6'd0;
            game_over_d = 1'b0;
            winner_p1_d = 1'b0;
            winner_p2_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            p1_health           <= MAX_HEALTH;
            p2_health           <= MAX_HEALTH;
            round_seconds       <= ROUND_SECONDS;
            tick_q              <= 6'd0;
            p1_iframe_q         <= 6'd0;
            p2_iframe_q         <= 6'd0;
            game_over_condition <= 1'b0;
            winner_p1           <= 1'b0;
            winner_p2           <= 1'b0;
        end else begin
            state_q             <= state_d;
            p1_health           <= p1_health_d;
            p2_health           <= p2_health_d;
            round_seconds       <= seconds_d;
            tick_q              <= tick_d;
            p1_iframe_q         <= p1_iframe_d;
            p2_iframe_q         <= p2_iframe_d;
            game_over_condition <= game_over_d;
            winner_p1           <= winner_p1_d;
            winner_p2           <= winner_p2_d;
        end
    end

endmodule

// File: tb/tb_health_round_tracker.sv
// -----------------------------------------------------------------------------
// tb_health_round_tracker
//
// Directed testbench for health_round_tracker with default parameters.
// Expected values are hand-computed from the block's behaviour
// (100 health, 10 / 2 damage, 30 invulnerability cycles, 99 s x 60 ticks).
// -----------------------------------------------------------------------------
module tb_health_round_tracker;

    logic       clk_game = 1'b0;
    logic       reset_n;
    logic       reset_gameplay;
    logic       timer_enable;
    logic       timer_reset;
    logic       p1_hit_p2;
    logic       p2_hit_p1;
    logic       p1_blocking;
    logic       p2_blocking;
    logic [7:0] p1_health;
    logic [7:0] p2_health;
    logic [6:0] round_seconds;
    logic       p1_invuln;
    logic       p2_invuln;
    logic       game_over_condition;
    logic       winner_p1;
    logic       winner_p2;

    int n_checks = 0;
    int n_fail   = 0;

    health_round_tracker dut (
        .clk_game            (clk_game),
        .reset_n             (reset_n),
        .reset_gameplay      (reset_gameplay),
        .timer_enable        (timer_enable),
        .timer_reset         (timer_reset),
        .p1_hit_p2           (p1_hit_p2),
        .p2_hit_p1           (p2_hit_p1),
        .p1_blocking         (p1_blocking),
        .p2_blocking         (p2_blocking),
        .p1_health           (p1_health),
        .p2_health           (p2_health),
        .round_seconds       (round_seconds),
        .p1_invuln           (p1_invuln),
        .p2_invuln           (p2_invuln),
        .game_over_condition (game_over_condition),
        .winner_p1           (winner_p1),
        .winner_p2           (winner_p2)
    );

    always #5 clk_game = ~clk_game;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_game);
            #1;
        end
    endtask

    // Pulse reset_gameplay, then release it so the next edge enters FIGHT.
    task automatic new_round();
        reset_gameplay = 1'b1;
        step();
        reset_gameplay = 1'b0;
        step();
    endtask

    task automatic check_fresh(input string tag);
        check({tag, "_p1"}, p1_health, 100);
        check({tag, "_p2"}, p2_health, 100);
        check({tag, "_sec"}, round_seconds, 99);
        check({tag, "_go"}, game_over_condition, 0);
        check({tag, "_w1"}, winner_p1, 0);
        check({tag, "_w2"}, winner_p2, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        reset_gameplay = 1'b1;
        timer_enable   = 1'b0;
        timer_reset    = 1'b0;
        p1_hit_p2      = 1'b0;
        p2_hit_p1      = 1'b0;
        p1_blocking    = 1'b0;
        p2_blocking    = 1'b0;
        #2;
        step(2);

        // ---------------- reset state ----------------
        check_fresh("rst");
        check("rst_inv1", p1_invuln, 0);
        check("rst_inv2", p2_invuln, 0);

        // ---------------- single unblocked hit ----------------
        reset_n = 1'b1;
        new_round();
        p1_hit_p2 = 1'b1;
        step();
        p1_hit_p2 = 1'b0;
        check("hit1_p2", p2_health, 90);
        check("hit1_p1", p1_health, 100);
        check("hit1_inv", p2_invuln, 1);
        step(29);
        check("hit1_inv_29", p2_invuln, 1);
        step();
        check("hit1_inv_30", p2_invuln, 0);

        // ---------------- held hit, unblocked then blocked ----------------
        new_round();
        p1_hit_p2 = 1'b1;
        step(40);
        p1_hit_p2 = 1'b0;
        check("held_p2", p2_health, 80);

        new_round();
        p2_blocking = 1'b1;
        p1_hit_p2   = 1'b1;
        step(40);
        p1_hit_p2   = 1'b0;
        p2_blocking = 1'b0;
        check("held_blk_p2", p2_health, 96);

        // ---------------- KO by ten spaced hits ----------------
        new_round();
        for (int i = 1; i <= 10; i++) begin
            p1_hit_p2 = 1'b1;
            step();
            p1_hit_p2 = 1'b0;
            if (i == 9) begin
                check("ko9_p2", p2_health, 10);
                check("ko9_go", game_over_condition, 0);
            end
            if (i < 10) step(31);
        end
        check("ko_p2", p2_health, 0);
        check("ko_go", game_over_condition, 1);
        check("ko_w1", winner_p1, 1);
        check("ko_w2", winner_p2, 0);
        // OVER ignores hits and timer controls.
        p1_hit_p2    = 1'b1;
        p2_hit_p1    = 1'b1;
        timer_enable = 1'b1;
        step(70);
        p1_hit_p2    = 1'b0;
        p2_hit_p1    = 1'b0;
        timer_enable = 1'b0;
        check("over_p1", p1_health, 100);
        check("over_p2", p2_health, 0);
        check("over_sec", round_seconds, 99);
        check("over_go", game_over_condition, 1);
        check("over_w1", winner_p1, 1);
        check("over_w2", winner_p2, 0);

        // ---------------- double KO draw ----------------
        new_round();
        for (int i = 1; i <= 10; i++) begin
            p1_hit_p2 = 1'b1;
            p2_hit_p1 = 1'b1;
            step();
            p1_hit_p2 = 1'b0;
            p2_hit_p1 = 1'b0;
            if (i == 9) begin
                check("dko9_p1", p1_health, 10);
                check("dko9_p2", p2_health, 10);
            end
            if (i < 10) step(31);
        end
        check("dko_p1", p1_health, 0);
        check("dko_p2", p2_health, 0);
        check("dko_go", game_over_condition, 1);
        check("dko_w1", winner_p1, 0);
        check("dko_w2", winner_p2, 0);

        // ---------------- time-up with P1 behind ----------------
        new_round();
        p2_hit_p1 = 1'b1;
        step();
        p2_hit_p1 = 1'b0;
        check("tu_p1", p1_health, 90);
        timer_enable = 1'b1;
        step(59);
        check("tu_59", round_seconds, 99);
        step();
        check("tu_60", round_seconds, 98);
        step(30);
        timer_reset = 1'b1;
        step();
        timer_reset = 1'b0;
        check("tu_treset", round_seconds, 99);
        step(59);
        check("tu_r59", round_seconds, 99);
        step();
        check("tu_r60", round_seconds, 98);
        for (int s = 97; s >= 0; s--) begin
            step(60);
            check($sformatf("tu_sec%0d", s), round_seconds, s);
            if (s == 1) check("tu_go_early", game_over_condition, 0);
        end
        check("tu_go", game_over_condition, 1);
        check("tu_w1", winner_p1, 0);
        check("tu_w2", winner_p2, 1);
        timer_reset = 1'b1;
        step();
        timer_reset = 1'b0;
        check("tu_frozen", round_seconds, 0);
        timer_enable = 1'b0;

        // ---------------- reset_gameplay from OVER ----------------
        reset_gameplay = 1'b1;
        step();
        check_fresh("rg_over");
        // Release together with a hit: entry edge must not apply damage.
        reset_gameplay = 1'b0;
        p1_hit_p2      = 1'b1;
        step();
        check("rg_idle_nodmg", p2_health, 100);
        step();
        p1_hit_p2 = 1'b0;
        check("rg_fight_dmg", p2_health, 90);

        // ---------------- reset_gameplay mid-FIGHT with a hit ----------------
        reset_gameplay = 1'b1;
        p2_hit_p1      = 1'b1;
        step();
        reset_gameplay = 1'b0;
        p2_hit_p1      = 1'b0;
        check_fresh("rg_mid");
        check("rg_mid_inv1", p1_invuln, 0);
        check("rg_mid_inv2", p2_invuln, 0);

        // ---------------- reset_n mid-FIGHT with a hit ----------------
        step();
        p1_hit_p2 = 1'b1;
        step();
        check("rn_pre_p2", p2_health, 90);
        p1_hit_p2 = 1'b0;
        reset_n   = 1'b0;
        p2_hit_p1 = 1'b1;
        step();
        reset_n   = 1'b1;
        p2_hit_p1 = 1'b0;
        check_fresh("rn_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
